seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Parametrised modulo-N pattern sequencer for a single Tiny Tapeout user slot: a step index counts through STEPS states and drives a 7-segment pattern looked up per step, plus a wrap pulse. It generalises the fixed 3-state flip-flop sequencer to configurable length, direction, hold, single-step and synchronous clear. It sits directly behind the 8-bit io_in/io_out slot pins.

## Interface

- STEPS, 3, number of sequence steps; legal 2..16.
- PATTERN, {7'h5B, 7'h06, 7'h3F}, packed STEPS×7 segment codes (gfedcba); entry k is shown at index k.
- IDX_W, $clog2(STEPS), derived; do not override.

- io_in[0]  input  1  clock; all state on rising edge.
- io_in[1]  input  1  reset; asynchronous, active-high.
- io_in[3:2]  input  2  mode: 00 RUN_UP, 01 HOLD, 10 STEP, 11 RUN_DOWN.
- io_in[4]  input  1  step button; asynchronous, synchronised internally.
- io_in[5]  input  1  synchronous clear to index 0.
- io_in[7:6]  input  2  prescale select (only with SEQGEN_PRESCALE_EN).
- io_out[6:0]  output  7  PATTERN[idx].
- io_out[7]  output  1  wrap pulse.

## Operation

- State: idx (IDX_W bits), wrap flag, button synchroniser, optional prescaler.
- Reset: idx=0, wrap=0, synchroniser and prescaler cleared; io_out = {1'b0, PATTERN[0]}.
- Advance enable adv: RUN_UP/RUN_DOWN → prescaler tick; STEP → one-cycle rising-edge pulse of synchronised io_in[4]; HOLD → 0.
- Up: idx==STEPS-1 → 0, else idx+1. Down: idx==0 → STEPS-1, else idx-1. idx never takes values ≥ STEPS.
- wrap registered: 1 for exactly the cycle after an advance crossing the boundary (STEPS-1→0 up, 0→STEPS-1 down), else 0.
- STEP mode advances upward only.
- Clear (io_in[5]=1) has priority over adv: idx←0, wrap←0, prescaler←0; held clear keeps idx at 0.
- Mode decode sampled each edge; mode change affects the next edge, no flush of idx.
- Button held high: exactly one advance per rising edge; edges while not in STEP mode are discarded.

## Timing

- io_out[6:0] is a combinational decode of registered idx: changes only after a clock edge or reset assertion.
- RUN modes, divide 1: idx changes every cycle; full period = STEPS cycles.
- STEP: io_in[4] rising before edge n → 2 synchroniser flops + edge register → idx changes at edge n+2.
- Reset assertion takes effect immediately, mid-sequence included; deassertion: first advance on the first edge with reset low.
- Clear and adv on same edge: clear wins, wrap=0.

## Configuration

- SEQGEN_PRESCALE_EN defined: 3-bit free-running prescaler; RUN tick every 2^io_in[7:6] cycles (1,2,4,8); tick on prescaler count wrap; prescaler reset by reset and clear; STEP mode unaffected.
- Undefined: tick=1 every cycle, io_in[7:6] ignored, no prescaler flops.

## Structure

- Package seq_pattern_gen_pkg: mode enum (MODE_RUN_UP, MODE_HOLD, MODE_STEP, MODE_RUN_DOWN), default PATTERN constant, segment code constants for digits 0–9.
- Sub-module sync_edge: 2-flop synchroniser plus rising-edge detector, asynchronous active-high reset to 0, single-cycle pulse output.
- Top holds index counter, wrap flag, prescaler, pattern mux.

## Test plan

- Reset with STEPS=3: io_out=0x3F immediately, wrap=0; stays through deassertion in HOLD.
- RUN_UP, STEPS=3: io_out 0x3F→0x06→0x5B→0x3F per cycle; io_out[7]=1 only on the cycle showing 0x3F after 0x5B.
- RUN_DOWN from idx 0: next 0x5B with wrap=1, then 0x06, 0x3F; STEPS=5 variant never shows idx≥5.
- STEP: io_in[4] held high 10 cycles → exactly one advance, 2 edges after sampling; second press → one more advance; presses in HOLD → none.
- Clear at idx 2 during RUN_UP with adv on same edge → idx 0, wrap 0; held clear keeps 0x3F.
- SEQGEN_PRESCALE_EN, io_in[7:6]=10: idx advances every 4th cycle; async reset mid-count → 0x3F instantly, prescaler restarts from 0.

Source files
------------

// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and constants for the seq_pattern_gen pattern sequencer.
// Segment codes are gfedcba, active-high.
package seq_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RUN_UP   = 2'b00,
    MODE_HOLD     = 2'b01,
    MODE_STEP     = 2'b10,
    MODE_RUN_DOWN = 2'b11
  } mode_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [20:0] DEFAULT_PATTERN = {SEG_2, SEG_1, SEG_0};

  // Low-bit mask whose all-ones state marks a prescaler tick for divide 2^sel.
  function automatic logic [2:0] prescale_mask(input logic [1:0] sel);
    case (sel)
      2'd0:    prescale_mask = 3'b000;
      2'd1:    prescale_mask = 3'b001;
      2'd2:    prescale_mask = 3'b011;
      2'd3:    prescale_mask = 3'b111;
      default: prescale_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seq_pattern_gen_sync.sv
// sync_edge: two-flop synchroniser for an asynchronous input followed by a
// rising-edge detector producing a single-cycle pulse.
module sync_edge
  import seq_pattern_gen_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchroniser chain plus previous-value register for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Modulo-STEPS 7-segment pattern sequencer for one Tiny Tapeout slot.
// Optional RUN-mode prescaler enabled by defining SEQGEN_PRESCALE_EN.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int                 STEPS   = 3,
  parameter logic [STEPS*7-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int                 IDX_W   = $clog2(STEPS)
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  logic       clk_s;
  logic       rst_s;
  logic       btn_s;
  logic       clr_s;
  mode_e      mode_s;
  logic       step_pulse_s;
  logic       tick_s;
  logic       adv_s;

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             wrap_q;
  logic             wrap_d;

  assign clk_s  = io_in[0];
  assign rst_s  = io_in[1];
  assign mode_s = mode_e'(io_in[3:2]);
  assign btn_s  = io_in[4];
  assign clr_s  = io_in[5];

  sync_edge u_sync_edge (
    .clk_i   (clk_s),
    .rst_i   (rst_s),
    .d_i     (btn_s),
    .pulse_o (step_pulse_s)
  );

`ifdef SEQGEN_PRESCALE_EN
  logic [2:0] presc_q;
  logic [2:0] presc_mask_s;

  // Free-running prescaler, restarted by clear
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      presc_q <= 3'd0;
    end else if (clr_s) begin
      presc_q <= 3'd0;
    end else begin
      presc_q <= presc_q + 3'd1;
    end
  end

  assign presc_mask_s = prescale_mask(io_in[7:6]);
  assign tick_s       = ((presc_q & presc_mask_s) == presc_mask_s);
`else
  logic unused_s;
  assign unused_s = ^io_in[7:6];
  assign tick_s   = 1'b1;
`endif

  // Advance enable from mode; STEP edges are ignored in every other mode
  always_comb begin
    adv_s = 1'b0;
    case (mode_s)
      MODE_RUN_UP:   adv_s = tick_s;
      MODE_RUN_DOWN: adv_s = tick_s;
      MODE_STEP:     adv_s = step_pulse_s;
      MODE_HOLD:     adv_s = 1'b0;
      default:       adv_s = 1'b0;
    endcase
  end

  // Next index and boundary-crossing flag; clear overrides any advance
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (clr_s) begin
      idx_d  = '0;
      wrap_d = 1'b0;
    end else if (adv_s) begin
      if (mode_s == MODE_RUN_DOWN) begin
        if (idx_q == '0) begin
          idx_d  = LAST_IDX;
          wrap_d = 1'b1;
        end else begin
          idx_d  = idx_q - IDX_W'(1);
          wrap_d = 1'b0;
        end
      end else begin
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          wrap_d = 1'b0;
        end
      end
    end else begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
    end
  end

  // Index and wrap state
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign io_out = {wrap_q, PATTERN[int'(idx_q) * 7 +: 7]};

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: STEPS=3 and STEPS=5 instances share
// the slot inputs; a reference model queues expected outputs per clock edge.
module tb_seq_pattern_gen;
  import seq_pattern_gen_pkg::*;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       btn  = 1'b0;
  logic       clr  = 1'b0;
  logic [1:0] mode = 2'b01;
  logic [1:0] sel  = 2'b00;
  logic [7:0] io_in;
  logic [7:0] out3;
  logic [7:0] out5;

  assign io_in = {sel, clr, btn, mode, rst, clk};

  seq_pattern_gen #(.STEPS(3)) dut3 (
    .io_in  (io_in),
    .io_out (out3)
  );

  seq_pattern_gen #(
    .STEPS   (5),
    .PATTERN ({7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F})
  ) dut5 (
    .io_in  (io_in),
    .io_out (out5)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] q3[$];
  logic [7:0] q5[$];
  logic [6:0] pat [5] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66};

  int         m3, m5;
  logic       w3, w5;
  logic       b1, b2, b3;
  logic [2:0] pc;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m3 = 0; m5 = 0; w3 = 1'b0; w5 = 1'b0;
    b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; pc = 3'd0;
  endtask

  // Reference behaviour for one rising edge using the inputs currently driven
  task automatic model_step();
    logic pulse, tk, adv;
    logic [2:0] mask;
    if (rst) begin
      model_reset();
    end else begin
      pulse = b2 & ~b3;
      tk = 1'b1;
`ifdef SEQGEN_PRESCALE_EN
      case (sel)
        2'd0: mask = 3'd0;
        2'd1: mask = 3'd1;
        2'd2: mask = 3'd3;
        default: mask = 3'd7;
      endcase
      tk = ((pc & mask) == mask);
`else
      mask = 3'd0;
`endif
      case (mode)
        2'b00, 2'b11: adv = tk;
        2'b10:        adv = pulse;
        default:      adv = 1'b0;
      endcase
      if (clr) begin
        m3 = 0; m5 = 0; w3 = 1'b0; w5 = 1'b0;
      end else if (adv && mode == 2'b11) begin
        w3 = (m3 == 0); m3 = (m3 == 0) ? 2 : m3 - 1;
        w5 = (m5 == 0); m5 = (m5 == 0) ? 4 : m5 - 1;
      end else if (adv) begin
        w3 = (m3 == 2); m3 = (m3 == 2) ? 0 : m3 + 1;
        w5 = (m5 == 4); m5 = (m5 == 4) ? 0 : m5 + 1;
      end else begin
        w3 = 1'b0; w5 = 1'b0;
      end
      b3 = b2; b2 = b1; b1 = btn;
      pc = clr ? 3'd0 : pc + 3'd1;
    end
  endtask

  task automatic push_exp();
    q3.push_back({w3, pat[m3]});
    q5.push_back({w5, pat[m5]});
  endtask

  task automatic pop_chk(input string tag);
    check_val({tag, "/s3"}, out3, q3.pop_front());
    check_val({tag, "/s5"}, out5, q5.pop_front());
  endtask

  task automatic cyc(input string tag, input int n);
    repeat (n) begin
      model_step();
      push_exp();
      @(posedge clk);
      @(negedge clk);
      pop_chk(tag);
    end
  endtask

  task automatic count_changes(input string tag, input int n, output int ch);
    logic [6:0] prv;
    ch  = 0;
    prv = out3[6:0];
    repeat (n) begin
      cyc(tag, 1);
      if (out3[6:0] !== prv) ch++;
      prv = out3[6:0];
    end
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    push_exp();
    pop_chk(tag);
    check_val({tag, "_const"}, out3, 8'h3F);
    @(negedge clk);
    cyc({tag, "_held"}, 1);
    rst = 1'b0;
  endtask

  initial begin
    int ch;
    model_reset();
    #1;
    push_exp();
    pop_chk("reset");
    check_val("reset_const", out3, 8'h3F);
    @(negedge clk);
    cyc("rst_held", 2);

    rst = 1'b0;
    cyc("hold", 3);
    check_val("hold_const", out3, 8'h3F);

    mode = 2'b00;
    cyc("run_up", 2);
    check_val("up_5b", out3, 8'h5B);
    cyc("run_up_wrap", 1);
    check_val("up_wrap", out3, 8'hBF);
    cyc("run_up", 4);

    for (int i = 0; i < 3 && m3 != 2; i++) cyc("to_idx2", 1);
    clr = 1'b1;
    cyc("clear", 1);
    check_val("clr_const", out3, 8'h3F);
    cyc("clr_held", 3);
    clr = 1'b0;

    mode = 2'b11;
    cyc("run_down", 1);
    check_val("down_wrap", out3, 8'hDB);
    cyc("run_down", 7);

    mode = 2'b10;
    btn  = 1'b1;
    count_changes("step1", 10, ch);
    check_val("step1_once", 8'(ch), 8'd1);
    btn = 1'b0;
    cyc("step_rel", 3);
    btn = 1'b1;
    count_changes("step2", 5, ch);
    check_val("step2_once", 8'(ch), 8'd1);
    btn = 1'b0;
    cyc("step_rel", 2);

    mode = 2'b01;
    btn  = 1'b1;
    count_changes("hold_btn", 4, ch);
    btn = 1'b0;
    cyc("hold_rel", 4);
    mode = 2'b10;
    count_changes("hold_then_step", 3, ch);
    check_val("hold_press_none", 8'(ch), 8'd0);

    mode = 2'b00;
    cyc("run_pre_rst", 2);
    async_reset("mid_rst");
    cyc("after_rst", 4);

    sel  = 2'b10;
    clr  = 1'b1;
    cyc("presc_clr", 1);
    clr  = 1'b0;
    cyc("presc", 10);
    async_reset("presc_rst");
    cyc("presc_after", 9);

    repeat (80) begin
      mode = 2'($urandom_range(0, 3));
      btn  = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 11) == 0);
      sel  = 2'($urandom_range(0, 3));
      cyc("rand", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
